scan_cfg_bank: RTL and testbench

//  Downstream consumer of the scan sub-chain address/shift front end.
//  - Tracks scan frame framing on scan_clk: a 12-bit address phase, then a data phase.
//  - On a correctly sized frame, commits the front end's 140-bit shift word into one of NUM_CHAINS configuration registers.
//  - Returns the addressed register as the parallel readback word, so old contents shift out while new contents shift in.

---
 rtl/scan_cfg_bank.sv | 157 +++++++++++++++
 tb/tb_scan_cfg_bank.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/scan_cfg_bank.sv
// scan_cfg_bank: frame tracker and configuration register bank behind the
// scan sub-chain address/shift front end.
//
// Frame format: ADDR_W address-phase cycles, then a data phase. When the data
// phase ends, the front end's shift word is committed into the addressed
// configuration register if the data-phase length matches the expected length.
//
// Optional feature macro: SCAN_CFG_READBACK_EN
//   defined   - the addressed register is returned on the parallel readback port
//               and the data phase is one cycle longer (the readback load cycle).
//   undefined - readback outputs are tied to 0 and no readback mux is built.
module scan_cfg_bank #(
    parameter int NUM_CHAINS = 11,
    parameter int DATA_W     = 140,
    parameter int ADDR_W     = 12,
    parameter int CNT_W      = 9
) (
    input  logic                         scan_clk,
    input  logic                         reset,
    input  logic                         scan_en,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DATA_W-1:0]            scan_in_data,
    output logic [NUM_CHAINS*DATA_W-1:0] cfg_out,
    output logic [NUM_CHAINS-1:0]        cfg_update,
    output logic [DATA_W-1:0]            scan_out_mux_output,
    output logic                         take_scanout_data,
    output logic                         len_err,
    output logic                         addr_err
);

    localparam int ACNT_W = $clog2(ADDR_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                                state, state_nxt;
    logic   [ACNT_W-1:0]                   acnt;
    logic   [CNT_W-1:0]                    cnt;
    logic   [NUM_CHAINS-1:0]               sel_oh;
    logic                                  sel_bad;
    logic                                  rb;
    logic   [NUM_CHAINS-1:0][DATA_W-1:0]   cfg;

    logic                                  addr_in_range;
    logic   [NUM_CHAINS-1:0]               addr_dec;
    logic                                  addr_done;
    logic                                  eval;
    logic                                  commit;
    logic                                  set_len_err;
    logic                                  set_addr_err;
    logic   [CNT_W-1:0]                    exp_len;

    // Address decode, shared by the select latch and the readback mux.
    always_comb begin
        addr_in_range = (addr < ADDR_W'(NUM_CHAINS));
        addr_dec      = '0;
        for (int i = 0; i < NUM_CHAINS; i++) begin
            addr_dec[i] = (addr == ADDR_W'(i));
        end
    end

    // Frame state register.
    always_ff @(posedge scan_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: a dropped enable aborts the address phase or ends the data phase.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (scan_en) state_nxt = ADDR;
            ADDR: begin
                if (!scan_en)       state_nxt = IDLE;
                else if (addr_done) state_nxt = DATA;
            end
            DATA:    if (!scan_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame-end decisions; address error wins over length error.
    always_comb begin
        addr_done    = (acnt == ACNT_W'(ADDR_W));
        exp_len      = CNT_W'(DATA_W) + CNT_W'(rb);
        eval         = (state == DATA) && !scan_en;
        set_addr_err = eval && sel_bad;
        set_len_err  = eval && !sel_bad && (cnt != exp_len);
        commit       = eval && !sel_bad && (cnt == exp_len);
    end

    // Address-phase and data-phase counters plus the select/readback latch.
    always_ff @(posedge scan_clk or posedge reset) begin
        if (reset) begin
            acnt    <= '0;
            cnt     <= '0;
            sel_oh  <= '0;
            sel_bad <= 1'b0;
            rb      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (scan_en) acnt <= ACNT_W'(1);
                ADDR: begin
                    if (scan_en) begin
                        if (addr_done) begin
                            sel_oh  <= addr_dec;
                            sel_bad <= !addr_in_range;
                            rb      <= take_scanout_data;
                            cnt     <= CNT_W'(1);
                        end else begin
                            acnt <= acnt + ACNT_W'(1);
                        end
                    end
                end
                DATA: if (scan_en && (cnt != '1)) cnt <= cnt + CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Configuration words, update pulse and sticky error flags.
    always_ff @(posedge scan_clk or posedge reset) begin
        if (reset) begin
            cfg        <= '0;
            cfg_update <= '0;
            len_err    <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            cfg_update <= commit ? sel_oh : '0;
            for (int i = 0; i < NUM_CHAINS; i++) begin
                if (commit && sel_oh[i]) cfg[i] <= scan_in_data;
            end
            if (set_len_err)  len_err  <= 1'b1;
            if (set_addr_err) addr_err <= 1'b1;
        end
    end

    assign cfg_out = cfg;

`ifdef SCAN_CFG_READBACK_EN
    // Readback of the addressed chain straight from the registered words.
    always_comb begin
        scan_out_mux_output = '0;
        for (int i = 0; i < NUM_CHAINS; i++) begin
            if (addr_dec[i]) scan_out_mux_output = cfg[i];
        end
        take_scanout_data = addr_in_range;
    end
`else
    assign scan_out_mux_output = '0;
    assign take_scanout_data   = 1'b0;
`endif

endmodule

// File: tb/tb_scan_cfg_bank.sv
// Directed self-checking bench for scan_cfg_bank. Expected values come from a
// small behavioural model of the frame rules kept in this file.
module tb_scan_cfg_bank;

    localparam int NUM_CHAINS = 11;
    localparam int DATA_W     = 140;
    localparam int ADDR_W     = 12;
    localparam int CNT_W      = 9;
`ifdef SCAN_CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int EXP = DATA_W + (RB ? 1 : 0);

    logic                         scan_clk = 1'b0;
    logic                         reset;
    logic                         scan_en;
    logic [ADDR_W-1:0]            addr;
    logic [DATA_W-1:0]            scan_in_data;
    logic [NUM_CHAINS*DATA_W-1:0] cfg_out;
    logic [NUM_CHAINS-1:0]        cfg_update;
    logic [DATA_W-1:0]            scan_out_mux_output;
    logic                         take_scanout_data;
    logic                         len_err;
    logic                         addr_err;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] model [NUM_CHAINS];
    logic              m_len_err, m_addr_err;
    logic [DATA_W-1:0] w1, w2, w3;

    scan_cfg_bank #(
        .NUM_CHAINS(NUM_CHAINS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .scan_clk            (scan_clk),
        .reset               (reset),
        .scan_en             (scan_en),
        .addr                (addr),
        .scan_in_data        (scan_in_data),
        .cfg_out             (cfg_out),
        .cfg_update          (cfg_update),
        .scan_out_mux_output (scan_out_mux_output),
        .take_scanout_data   (take_scanout_data),
        .len_err             (len_err),
        .addr_err            (addr_err)
    );

    always #5 scan_clk = ~scan_clk;

    task automatic tick();
        @(posedge scan_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CHAINS; i++) model[i] = '0;
        m_len_err  = 1'b0;
        m_addr_err = 1'b0;
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < NUM_CHAINS; i++)
            chk($sformatf("%s_cfg%0d", tag, i), cfg_out[i*DATA_W +: DATA_W], model[i]);
        chk({tag, "_len_err"},  DATA_W'(len_err),  DATA_W'(m_len_err));
        chk({tag, "_addr_err"}, DATA_W'(addr_err), DATA_W'(m_addr_err));
    endtask

    // One frame: 12 address cycles, n data cycles, then scan_en low (evaluate).
    task automatic frame(input string tag, input int a, input int n, input logic [DATA_W-1:0] w);
        logic              in_range, rb_m, commit;
        logic [DATA_W-1:0] exp_upd, exp_mux;
        in_range     = (a < NUM_CHAINS);
        rb_m         = RB && in_range;
        addr         = ADDR_W'(a);
        scan_in_data = w;
        scan_en      = 1'b1;
        tick();
        chk({tag, "_upd_idle"}, DATA_W'(cfg_update), '0);
        repeat (ADDR_W - 1) tick();
        // first data-phase cycle: readback of old contents
        exp_mux = (rb_m) ? model[a] : '0;
        chk({tag, "_take"}, DATA_W'(take_scanout_data), DATA_W'(rb_m));
        chk({tag, "_mux"},  scan_out_mux_output, exp_mux);
        repeat (n) tick();
        chk({tag, "_upd_data"}, DATA_W'(cfg_update), '0);
        scan_en = 1'b0;
        tick();
        commit  = 1'b0;
        exp_upd = '0;
        if (!in_range)                   m_addr_err = 1'b1;
        else if (n != DATA_W + int'(rb_m)) m_len_err  = 1'b1;
        else begin
            commit     = 1'b1;
            model[a]   = w;
            exp_upd[a] = 1'b1;
        end
        chk({tag, "_upd"}, DATA_W'(cfg_update), exp_upd);
        check_state(tag);
        if (commit && RB)
            chk({tag, "_mux_new"}, scan_out_mux_output, w);
    endtask

    initial begin
        w1 = {{17{8'hA5}}, 4'hA};
        w2 = {35{4'h3}};
        w3 = {$urandom, $urandom, $urandom, $urandom, 12'h5C3};

        reset        = 1'b1;
        scan_en      = 1'b0;
        addr         = '0;
        scan_in_data = '0;
        model_reset();
        #12;
        check_state("rst");
        chk("rst_upd",  DATA_W'(cfg_update), '0);
        chk("rst_take", DATA_W'(take_scanout_data), DATA_W'(RB));
        @(negedge scan_clk);
        reset = 1'b0;
        tick();

        // write chain 3, then a second frame to chain 3 reads the old word back
        frame("wr3", 3, EXP, w1);
        frame("rb3", 3, EXP, w2);

        // abort in the address phase, then back-to-back frames with no gap
        addr    = ADDR_W'(2);
        scan_en = 1'b1;
        repeat (6) tick();
        scan_en = 1'b0;
        tick();
        chk("abort_upd", DATA_W'(cfg_update), '0);
        check_state("abort");
        frame("wr7", 7, EXP, w3);
        frame("wr8", 8, EXP, w1);

        // short frame flags length, following good frame still commits
        frame("short5", 5, 100, w2);
        frame("wr5", 5, EXP, w3);
        frame("long1", 1, EXP + 1, w2);

        // out-of-range address: no readback, address error
        addr = ADDR_W'(11);
        #1;
        chk("bad_take", DATA_W'(take_scanout_data), '0);
        chk("bad_mux",  scan_out_mux_output, '0);
        frame("bad11", 11, 141, w1);

        // reset in the middle of the data phase discards the frame
        addr         = ADDR_W'(4);
        scan_in_data = w2;
        scan_en      = 1'b1;
        repeat (ADDR_W + 50) tick();
        reset = 1'b1;
        #2;
        model_reset();
        check_state("midrst");
        scan_en = 1'b0;
        @(negedge scan_clk);
        reset = 1'b0;
        tick();
        chk("midrst_upd", DATA_W'(cfg_update), '0);
        check_state("postrst");

        // length 140 vs 141 at chain 0; outcome depends on readback build
        frame("len140", 0, 140, w1);
        frame("len141", 0, 141, w2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
